// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - operand/result handshake bundle for seq_alu
interface seq_alu_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       FS;
    logic [SHW-1:0]   SH;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F;
    logic [WIDTH-1:0] R;
    logic             Z;
    logic             V;
    logic             N;
    logic             C;
    logic             busy;

    modport master (
        output in_valid, A, B, FS, SH, out_ready,
        input  in_ready, out_valid, F, R, Z, V, N, C, busy
    );

    modport slave (
        input  in_valid, A, B, FS, SH, out_ready,
        output in_ready, out_valid, F, R, Z, V, N, C, busy
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: single-cycle logic/arith/shift ops, iterative MUL and DIVU
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    localparam logic [4:0] OP_PASS = 5'b00000, OP_ADD = 5'b00010, OP_SUB = 5'b00101,
                           OP_AND  = 5'b01000, OP_OR  = 5'b01010, OP_XOR = 5'b01100,
                           OP_NOT  = 5'b01110, OP_LSL = 5'b10000, OP_LSR = 5'b10001,
                           OP_ASR  = 5'b10010, OP_MUL = 5'b10100, OP_DIVU = 5'b10110;
    localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nxt;

    logic                 accept;
    logic [WIDTH-1:0]     a_r, b_r;
    logic                 is_div;
    logic [SHW:0]         cnt;
    logic [2*WIDTH-1:0]   p, p_nxt;

    logic [WIDTH-1:0]     sc_f;
    logic                 sc_c, sc_v, sc_iter;
    logic [WIDTH:0]       sum, diff, lsl, lsr;
    logic signed [WIDTH:0] asr;

    logic [WIDTH:0]       mul_sum, div_shift;
    logic [WIDTH-1:0]     div_sub;
    logic                 div_ge;
    logic [WIDTH-1:0]     it_f, it_r;
    logic                 it_v;

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = sc_iter ? EXEC : DONE;
            EXEC: if (cnt == LAST) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready is masked by rst so an op offered during reset is never taken
    always_comb begin
        bus.in_ready  = (state == IDLE) && !rst;
        bus.busy      = (state == EXEC);
        bus.out_valid = (state == DONE);
    end

    always_comb begin
        sc_f    = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sc_iter = 1'b0;
        sum  = {1'b0, bus.A} + {1'b0, bus.B};
        diff = {1'b0, bus.A} - {1'b0, bus.B};
        lsl  = {1'b0, bus.A} << bus.SH;
        lsr  = {bus.A, 1'b0} >> bus.SH;
        asr  = $signed({bus.A, 1'b0}) >>> bus.SH;
        case (bus.FS)
            OP_PASS: sc_f = bus.A;
            OP_ADD: begin
                {sc_c, sc_f} = sum;
                sc_v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                {sc_c, sc_f} = diff;
                sc_v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND:  sc_f = bus.A & bus.B;
            OP_OR:   sc_f = bus.A | bus.B;
            OP_XOR:  sc_f = bus.A ^ bus.B;
            OP_NOT:  sc_f = ~bus.A;
            // the extra guard bit catches the last bit shifted out; it stays 0 for SH=0
            OP_LSL:  {sc_c, sc_f} = lsl;
            OP_LSR:  {sc_f, sc_c} = lsr;
            OP_ASR:  {sc_f, sc_c} = asr;
            OP_MUL, OP_DIVU: sc_iter = 1'b1;
            default: sc_f = '0;
        endcase
    end

    // p holds {hi,lo}: MUL keeps {partial product, multiplier}, DIVU keeps {remainder, quotient}
    always_comb begin
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a_r} : '0);
        div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_r});
        div_sub   = div_shift[WIDTH-1:0] - b_r;
        if (is_div)
            p_nxt = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), p[WIDTH-2:0], div_ge};
        else
            p_nxt = {mul_sum, p[WIDTH-1:1]};
    end

    always_comb begin
        it_f = p_nxt[WIDTH-1:0];
        it_r = '0;
        it_v = 1'b0;
        if (is_div) begin
            if (b_r == '0) begin
                it_f = '1;
                it_r = a_r;
                it_v = 1'b1;
            end else begin
                it_r = p_nxt[2*WIDTH-1:WIDTH];
            end
        end else begin
            it_v = |p_nxt[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0; b_r <= '0; is_div <= 1'b0; cnt <= '0; p <= '0;
            bus.F <= '0; bus.R <= '0;
            bus.Z <= 1'b0; bus.V <= 1'b0; bus.N <= 1'b0; bus.C <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_r    <= bus.A;
                    b_r    <= bus.B;
                    is_div <= (bus.FS == OP_DIVU);
                    cnt    <= '0;
                    p      <= {{WIDTH{1'b0}}, (bus.FS == OP_DIVU) ? bus.A : bus.B};
                    if (!sc_iter) begin
                        bus.F <= sc_f;
                        bus.R <= '0;
                        bus.Z <= (sc_f == '0);
                        bus.N <= sc_f[WIDTH-1];
                        bus.V <= sc_v;
                        bus.C <= sc_c;
                    end
                end
                EXEC: begin
                    p   <= p_nxt;
                    cnt <= cnt + {{SHW{1'b0}}, 1'b1};
                    if (cnt == LAST) begin
                        bus.F <= it_f;
                        bus.R <= it_r;
                        bus.Z <= (it_f == '0);
                        bus.N <= it_f[WIDTH-1];
                        bus.V <= it_v;
                        bus.C <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed-vector bench for seq_alu at WIDTH=32
module tb_seq_alu;
    localparam logic [4:0] PASS_ = 5'b00000, ADD = 5'b00010, SUB = 5'b00101, XOR_ = 5'b01100,
                           NOT_ = 5'b01110, LSL = 5'b10000, LSR = 5'b10001, ASR = 5'b10010,
                           MUL = 5'b10100, DIVU = 5'b10110, UNDEF = 5'b11111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   lat, nbusy, nvalid;
    logic timeout;

    seq_alu_if #(.WIDTH(32)) bus ();
    seq_alu #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // flags packed as {Z,V,N,C}
    function automatic logic [3:0] flags();
        return {bus.Z, bus.V, bus.N, bus.C};
    endfunction

    task automatic run(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
        @(negedge clk);
        chk("in_ready_idle", bus.in_ready, 1'b1);
        bus.FS = fs; bus.A = a; bus.B = b; bus.SH = sh; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A = 32'hDEADBEEF; bus.B = 32'h0000_1234; bus.FS = ADD; bus.SH = 5'd3;
        lat = 0; nbusy = 0; timeout = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (bus.busy) nbusy++;
            if (bus.out_valid) begin
                timeout = 1'b0;
                break;
            end
        end
        if (timeout) chk("timeout", 1'b1, 1'b0);
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.FS = '0; bus.SH = '0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_F", bus.F, 32'h0);
        chk("rst_R", bus.R, 32'h0);
        chk("rst_flags", flags(), 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);

        run(ADD, 32'h7FFFFFFF, 32'h1, 5'd0);
        chk("add_lat", lat, 1);
        chk("add_F", bus.F, 32'h80000000);
        chk("add_flags", flags(), 4'b0110);
        take();

        run(ADD, 32'hFFFFFFFF, 32'h1, 5'd0);
        chk("add_carry_F", bus.F, 32'h0);
        chk("add_carry_flags", flags(), 4'b1001);
        take();

        run(SUB, 32'd5, 32'd5, 5'd0);
        chk("sub_eq_F", bus.F, 32'h0);
        chk("sub_eq_flags", flags(), 4'b1000);
        take();

        run(SUB, 32'd3, 32'd5, 5'd0);
        chk("sub_borrow_F", bus.F, 32'hFFFFFFFE);
        chk("sub_borrow_flags", flags(), 4'b0011);
        take();

        run(ASR, 32'h80000010, 32'h0, 5'd4);
        chk("asr_F", bus.F, 32'hF8000001);
        chk("asr_flags", flags(), 4'b0010);
        take();

        run(LSL, 32'h80000001, 32'h0, 5'd1);
        chk("lsl_F", bus.F, 32'h00000002);
        chk("lsl_flags", flags(), 4'b0001);
        take();

        run(LSL, 32'h80000000, 32'h0, 5'd0);
        chk("lsl_sh0_F", bus.F, 32'h80000000);
        chk("lsl_sh0_flags", flags(), 4'b0010);
        take();

        run(LSR, 32'h00000003, 32'h0, 5'd1);
        chk("lsr_F", bus.F, 32'h00000001);
        chk("lsr_flags", flags(), 4'b0001);
        take();

        run(NOT_, 32'h0, 32'h0, 5'd0);
        chk("not_F", bus.F, 32'hFFFFFFFF);
        chk("not_flags", flags(), 4'b0010);
        take();

        run(UNDEF, 32'd5, 32'd9, 5'd2);
        chk("undef_lat", lat, 1);
        chk("undef_F", bus.F, 32'h0);
        chk("undef_flags", flags(), 4'b1000);
        take();

        run(MUL, 32'h00010000, 32'h00010000, 5'd0);
        chk("mul_lat", lat, 33);
        chk("mul_busy_cycles", nbusy, 32);
        chk("mul_F", bus.F, 32'h0);
        chk("mul_flags", flags(), 4'b1100);
        take();

        run(MUL, 32'd12345, 32'd100, 5'd0);
        chk("mul_small_F", bus.F, 32'h0012D644);
        chk("mul_small_flags", flags(), 4'b0000);
        take();

        run(DIVU, 32'd100, 32'd7, 5'd0);
        chk("div_lat", lat, 33);
        chk("div_F", bus.F, 32'd14);
        chk("div_R", bus.R, 32'd2);
        take();

        run(DIVU, 32'd100, 32'd0, 5'd0);
        chk("div0_lat", lat, 33);
        chk("div0_F", bus.F, 32'hFFFFFFFF);
        chk("div0_R", bus.R, 32'd100);
        chk("div0_flags", flags(), 4'b0110);
        take();

        // back-pressure: result held while a competing op is offered
        run(XOR_, 32'hF0F0F0F0, 32'hFFFF0000, 5'd0);
        bus.FS = PASS_; bus.A = 32'h11111111; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1'b1);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_F", bus.F, 32'h0F0FF0F0);
            chk("bp_flags", flags(), 4'b0000);
        end
        bus.in_valid = 1'b0;
        take();
        @(negedge clk);
        chk("bp_release_idle", bus.in_ready, 1'b1);
        chk("bp_release_valid", bus.out_valid, 1'b0);

        // reset in the middle of a MUL
        bus.FS = MUL; bus.A = 32'd3; bus.B = 32'd4; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("exec_busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_in_ready", bus.in_ready, 1'b0);
        chk("abort_F", bus.F, 32'h0);
        rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) nvalid++;
        end
        chk("abort_no_valid", nvalid, 0);

        // rst together with in_valid: op must not be taken
        rst = 1'b1;
        bus.FS = ADD; bus.A = 32'd1; bus.B = 32'd2; bus.in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_pri_idle", bus.in_ready, 1'b1);
        chk("rst_pri_valid", bus.out_valid, 1'b0);

        run(DIVU, 32'd1000, 32'd10, 5'd0);
        chk("post_abort_lat", lat, 33);
        chk("post_abort_F", bus.F, 32'd100);
        chk("post_abort_R", bus.R, 32'd0);
        take();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning an operation is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block can accept an operation.
REQ-007 The block SHALL have ports A and B, input, WIDTH, operands A and B.
REQ-008 The block SHALL have port FS, input, 5, the function select.
REQ-009 The block SHALL have port SH, input, SHW, the shift amount.
REQ-010 The block SHALL have port out_valid, output, 1, meaning a result is held.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-012 The block SHALL have port F, output, WIDTH, the result.
REQ-013 The block SHALL have port R, output, WIDTH, the DIVU remainder; it is 0 for every other op.
REQ-014 The block SHALL have ports Z, V, N and C, output, 1 each: the zero, overflow, negative and carry flags.
REQ-015 The block SHALL have port busy, output, 1, high in the EXEC state.

Function
REQ-016 The block SHALL implement FSM states IDLE, EXEC and DONE, with in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-017 The block SHALL register A, B, FS and SH on acceptance (in_valid&&in_ready) and ignore input changes thereafter.
REQ-018 The block SHALL implement single-cycle ops as follows: 00000 PASS F=A; 00010 ADD; 00101 SUB; 01000 AND; 01010 OR; 01100 XOR; 01110 NOT F=~A; 10000 LSL; 10001 LSR; 10010 ASR.
REQ-019 For single-cycle ops accepted at edge t, the block SHALL go IDLE->DONE with out_valid=1 after edge t+1.
REQ-020 The block SHALL implement iterative ops 10100 MUL (unsigned shift-add) and 10110 DIVU (unsigned restoring), each going IDLE->EXEC for exactly WIDTH cycles, then DONE; out_valid SHALL rise WIDTH+1 cycles after acceptance.
REQ-021 In DONE, the block SHALL hold F, R and the flags stable until out_ready=1, then go DONE->IDLE on that edge; no new op SHALL be accepted in the same cycle.
REQ-022 For ADD, the block SHALL compute {C,F}=A+B, with V=1 iff the operand sign bits are equal and differ from F[MSB].
REQ-023 For SUB, the block SHALL compute {C,F}=A-B (C=1 means borrow, A<B unsigned), with V=1 iff the operand sign bits differ and F[MSB]!=A[MSB].
REQ-024 For shifts, C SHALL be the last bit shifted out, and C=0 when SH=0.
REQ-025 ASR SHALL replicate A[MSB].
REQ-026 For MUL, F SHALL be the low WIDTH bits of A*B, with V=1 iff the high WIDTH bits are nonzero and C=0.
REQ-027 For DIVU, F SHALL be the quotient and R the remainder.
REQ-028 For DIVU with B=0, F SHALL be all-ones, R=A, V=1 and C=0, with unchanged latency.
REQ-029 For all ops, Z SHALL be (F==0) and N SHALL be F[MSB]; V=0 and C=0 unless stated otherwise.
REQ-030 For an undefined FS, the block SHALL produce F=0, R=0, Z=1 and all other flags 0, with single-cycle latency.
REQ-031 The block SHALL keep the EXEC iteration counter SHW+1 bits wide, with no wrap before WIDTH iterations.

Reset
REQ-032 When rst=1, on the next edge the block SHALL go to IDLE, with out_valid=0, busy=0, F=0, R=0 and Z=V=N=C=0.
REQ-033 When rst=1, the block SHALL hold in_ready=0 during the rst cycle and drive in_ready=1 from the first cycle after rst deasserts.
REQ-034 A rst asserted during EXEC or DONE SHALL abort the op and discard the result; no out_valid pulse SHALL follow.
REQ-035 A rst asserted together with in_valid SHALL take priority; the op is not accepted.

Verification
REQ-036 A bench SHALL check ADD, WIDTH=32: A=0x7FFFFFFF, B=1 -> F=0x80000000, V=1, N=1, C=0, Z=0; out_valid one cycle after acceptance.
REQ-037 A bench SHALL check SUB: A=5, B=5 -> F=0, Z=1, C=0. It SHALL also check A=3, B=5 -> F=0xFFFFFFFE, C=1, N=1, V=0.
REQ-038 A bench SHALL check ASR: A=0x80000010, SH=4 -> F=0xF8000001, C=0. It SHALL also check LSL: A=0x80000001, SH=1 -> F=0x00000002, C=1.
REQ-039 A bench SHALL check MUL: A=0x10000, B=0x10000 -> F=0, Z=1, V=1. The bench SHALL also check that out_valid rises exactly 33 cycles after acceptance and busy=1 for 32 cycles.
REQ-040 A bench SHALL check DIVU: A=100, B=7 -> F=14, R=2. It SHALL also check B=0 -> F=0xFFFFFFFF, R=100, V=1.
REQ-041 A bench SHALL check back-pressure and reset: hold out_ready=0 for 5 cycles -> F and flags stable, in_ready=0. It SHALL then assert rst mid-EXEC -> IDLE next edge, out_valid never asserts, and the next op completes correctly.
